// File: rtl/mega_ram_io.sv
// -----------------------------------------------------------------------------
// mega_ram_io
//
// Data-memory and board-I/O decoder sitting between the CPU core and its
// board I/O. One CPU data address is decoded into:
//   RAM   : A <  RAM_DEPTH
//   OUTk  : A == IO_BASE + k                 (k = 0..N_OUT-1)
//   INi   : A == IO_BASE + N_OUT + i         (i = 0..N_IN-1)
//   STAT  : A == IO_BASE + N_OUT + N_IN      (input-change flags, read-to-clear)
// Every other address reads 0 and ignores writes.
//
// Optional feature macro: MEGA_RAM_IO_SYNC_EN
//   defined   -> each input port passes through a 2-flop synchronizer
//                (adds 2 cycles of latency to INi reads and change flags)
//   undefined -> input ports are used directly
//
// Ports
//   CLK         in   system clock, all state updates on posedge
//   RESET_N     in   synchronous active-low reset
//   CLK_EX      in   execute-phase qualifier, writes only happen when high
//   RAM_ADDR    in   CPU data address
//   RAM_IN      in   CPU write data
//   RAM_WEN     in   CPU write request
//   IO_IN       in   input ports, port i = IO_IN[i*DATA_W +: DATA_W]
//   RAM_OUT     out  registered read data (latency 1)
//   IO_OUT      out  output registers, port k = IO_OUT[k*DATA_W +: DATA_W]
//   IO_OUT_STB  out  one-cycle pulse per output-register write
// -----------------------------------------------------------------------------
module mega_ram_io #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int RAM_DEPTH = 64,
    parameter int IO_BASE   = 64,
    parameter int N_OUT     = 1,
    parameter int N_IN      = 1
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    CLK_EX,
    input  logic [ADDR_W-1:0]       RAM_ADDR,
    input  logic [DATA_W-1:0]       RAM_IN,
    input  logic                    RAM_WEN,
    input  logic [N_IN*DATA_W-1:0]  IO_IN,
    output logic [DATA_W-1:0]       RAM_OUT,
    output logic [N_OUT*DATA_W-1:0] IO_OUT,
    output logic [N_OUT-1:0]        IO_OUT_STB
);

    localparam int RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int IN_BASE   = IO_BASE + N_OUT;
    localparam int STAT_ADDR = IN_BASE + N_IN;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]             mem_q [RAM_DEPTH];
    logic [DATA_W-1:0]             rd_q,     rd_d;
    logic [N_OUT-1:0][DATA_W-1:0]  out_q,    out_d;
    logic [N_OUT-1:0]              stb_q,    stb_d;
    logic [N_IN-1:0]               flag_q,   flag_d;
    logic [N_IN*DATA_W-1:0]        prev_q,   prev_d;
    // Low for the first cycle after reset so the initial load of prev_q
    // does not register as an input change.
    logic                          primed_q, primed_d;

    // ------------------------------------------------------------------
    // Decode / control
    // ------------------------------------------------------------------
    logic [31:0]             addr_s;
    logic                    we_s;
    logic                    ram_hit_s;
    logic [N_OUT-1:0]        out_hit_s;
    logic [N_IN-1:0]         in_hit_s;
    logic                    stat_hit_s;
    logic                    clear_s;
    logic [N_IN-1:0]         set_s;
    logic [DATA_W-1:0]       stat_s;
    logic [RAM_AW-1:0]       ram_idx_s;
    logic [N_IN*DATA_W-1:0]  sample_s;

    assign addr_s    = 32'(RAM_ADDR);
    assign we_s      = RAM_WEN & CLK_EX;
    assign ram_idx_s = RAM_ADDR[RAM_AW-1:0];

`ifdef MEGA_RAM_IO_SYNC_EN
    logic [N_IN*DATA_W-1:0] sync1_q;
    logic [N_IN*DATA_W-1:0] sync2_q;

    // Two-flop synchronizer on the board inputs.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sync1_q <= {(N_IN*DATA_W){1'b0}};
            sync2_q <= {(N_IN*DATA_W){1'b0}};
        end else begin
            sync1_q <= IO_IN;
            sync2_q <= sync1_q;
        end
    end

    assign sample_s = sync2_q;
`else
    assign sample_s = IO_IN;
`endif

    // Full-width address decode (no legacy index wrap).
    always_comb begin
        ram_hit_s  = (addr_s < 32'(RAM_DEPTH));
        stat_hit_s = (addr_s == 32'(STAT_ADDR));
        out_hit_s  = {N_OUT{1'b0}};
        in_hit_s   = {N_IN{1'b0}};
        for (int k = 0; k < N_OUT; k++) begin
            out_hit_s[k] = (addr_s == 32'(IO_BASE + k));
        end
        for (int i = 0; i < N_IN; i++) begin
            in_hit_s[i] = (addr_s == 32'(IN_BASE + i));
        end
    end

    // Read mux, output-register update, change detection and flag update.
    always_comb begin
        rd_d     = {DATA_W{1'b0}};
        out_d    = out_q;
        stb_d    = {N_OUT{1'b0}};
        set_s    = {N_IN{1'b0}};
        stat_s   = {DATA_W{1'b0}};
        prev_d   = sample_s;
        primed_d = 1'b1;

        stat_s[N_IN-1:0] = flag_q;

        // Read data always reflects the state before this edge's write.
        if (ram_hit_s) begin
            rd_d = mem_q[ram_idx_s];
        end else begin
            rd_d = {DATA_W{1'b0}};
        end

        // Mapped regions are disjoint, so at most one term below is non-zero.
        for (int k = 0; k < N_OUT; k++) begin
            rd_d = rd_d | (out_hit_s[k] ? out_q[k] : {DATA_W{1'b0}});
            if (we_s && out_hit_s[k]) begin
                out_d[k] = RAM_IN;
                stb_d[k] = 1'b1;
            end else begin
                out_d[k] = out_q[k];
                stb_d[k] = 1'b0;
            end
        end

        for (int i = 0; i < N_IN; i++) begin
            rd_d = rd_d | (in_hit_s[i] ? sample_s[i*DATA_W +: DATA_W] : {DATA_W{1'b0}});
            set_s[i] = primed_q &&
                       (sample_s[i*DATA_W +: DATA_W] != prev_q[i*DATA_W +: DATA_W]);
        end

        rd_d = rd_d | (stat_hit_s ? stat_s : {DATA_W{1'b0}});

        // A STAT read clears the flags after they are captured into rd_q;
        // a coinciding new change still sets its flag so no event is lost.
        clear_s = stat_hit_s && !we_s;
        if (clear_s) begin
            flag_d = set_s;
        end else begin
            flag_d = flag_q | set_s;
        end
    end

    // Data RAM: not cleared by reset, but reset blocks a coinciding write.
    always_ff @(posedge CLK) begin
        if (RESET_N && we_s && ram_hit_s) begin
            mem_q[ram_idx_s] <= RAM_IN;
        end
    end

    // Control/status registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            rd_q     <= {DATA_W{1'b0}};
            out_q    <= {(N_OUT*DATA_W){1'b0}};
            stb_q    <= {N_OUT{1'b0}};
            flag_q   <= {N_IN{1'b0}};
            prev_q   <= {(N_IN*DATA_W){1'b0}};
            primed_q <= 1'b0;
        end else begin
            rd_q     <= rd_d;
            out_q    <= out_d;
            stb_q    <= stb_d;
            flag_q   <= flag_d;
            prev_q   <= prev_d;
            primed_q <= primed_d;
        end
    end

    assign RAM_OUT    = rd_q;
    assign IO_OUT     = out_q;
    assign IO_OUT_STB = stb_q;

endmodule

// File: tb/tb_mega_ram_io.sv
// -----------------------------------------------------------------------------
// tb_mega_ram_io
//
// Directed stimulus for mega_ram_io with default parameters
// (RAM 0..63, OUT0 = 64, IN0 = 65, STAT = 66, 67+ unmapped).
// The driver pushes the expected values for the upcoming clock edge into a
// queue; a monitor running on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_mega_ram_io;

`ifdef MEGA_RAM_IO_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    localparam int K_RD  = 0;
    localparam int K_OUT = 1;
    localparam int K_STB = 2;

    logic        clk;
    logic        reset_n;
    logic        clk_ex;
    logic [7:0]  ram_addr;
    logic [15:0] ram_in;
    logic        ram_wen;
    logic [15:0] io_in;
    logic [15:0] ram_out;
    logic [15:0] io_out;
    logic [0:0]  io_out_stb;

    mega_ram_io dut (
        .CLK        (clk),
        .RESET_N    (reset_n),
        .CLK_EX     (clk_ex),
        .RAM_ADDR   (ram_addr),
        .RAM_IN     (ram_in),
        .RAM_WEN    (ram_wen),
        .IO_IN      (io_in),
        .RAM_OUT    (ram_out),
        .IO_OUT     (io_out),
        .IO_OUT_STB (io_out_stb)
    );

    typedef struct {
        int          due;
        int          kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc_cnt = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges so expectations can be tagged with their due edge.
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: compare every expectation whose edge has already happened.
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] act;
        while (q.size() > 0 && q[0].due <= cyc_cnt) begin
            e = q.pop_front();
            case (e.kind)
                K_RD:    act = ram_out;
                K_OUT:   act = io_out;
                K_STB:   act = {15'd0, io_out_stb};
                default: act = 16'hxxxx;
            endcase
            n_cmp = n_cmp + 1;
            if (act !== e.val) begin
                n_bad = n_bad + 1;
                $display("FAIL %s: got %h expected %h (edge %0d)", e.name, act, e.val, e.due);
            end
        end
    end

    task automatic drv(input logic rstn, input logic [7:0] a, input logic [15:0] d,
                       input logic wen, input logic ex);
        reset_n  = rstn;
        ram_addr = a;
        ram_in   = d;
        ram_wen  = wen;
        clk_ex   = ex;
    endtask

    task automatic chk(input int kind, input string name, input logic [15:0] v);
        exp_t e;
        e.due  = cyc_cnt + 1;
        e.kind = kind;
        e.val  = v;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        fork
            begin
                #200000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        io_in = 16'h0000;
        drv(1'b0, 8'd64, 16'h0000, 1'b0, 1'b0); tick();
        drv(1'b0, 8'd64, 16'h0000, 1'b0, 1'b0);
        chk(K_RD, "rst_rdata", 16'h0000);
        chk(K_OUT, "rst_out", 16'h0000);
        chk(K_STB, "rst_stb", 16'h0000);
        tick();

        drv(1'b1, 8'd66, 16'h0000, 1'b0, 1'b0); chk(K_RD, "stat_after_rst", 16'h0000); tick();

        // RAM write / read and CLK_EX qualification
        drv(1'b1, 8'd5, 16'hBEEF, 1'b1, 1'b1); tick();
        drv(1'b1, 8'd6, 16'h0606, 1'b1, 1'b1); tick();
        drv(1'b1, 8'd5, 16'h0000, 1'b0, 1'b0); chk(K_RD, "ram_rd5", 16'hBEEF); tick();
        drv(1'b1, 8'd5, 16'h1234, 1'b1, 1'b0); chk(K_RD, "ram_noex_rd", 16'hBEEF); tick();
        drv(1'b1, 8'd5, 16'h0000, 1'b0, 1'b0); chk(K_RD, "ram_noex_keep", 16'hBEEF); tick();

        // Output register write, strobe and read-during-write
        drv(1'b1, 8'd64, 16'hA5A5, 1'b1, 1'b1);
        chk(K_RD, "out_rdw_old", 16'h0000);
        chk(K_OUT, "out_wr", 16'hA5A5);
        chk(K_STB, "stb_on", 16'h0001);
        tick();
        drv(1'b1, 8'd64, 16'h0000, 1'b0, 1'b0);
        chk(K_RD, "out_rd", 16'hA5A5);
        chk(K_STB, "stb_off", 16'h0000);
        tick();
        drv(1'b1, 8'd63, 16'h0001, 1'b1, 1'b1);
        chk(K_OUT, "out_keep63", 16'hA5A5);
        chk(K_STB, "stb_ram63", 16'h0000);
        tick();
        drv(1'b1, 8'd63, 16'h0000, 1'b0, 1'b0); chk(K_RD, "ram_rd63", 16'h0001); tick();

        // Back-to-back output writes
        drv(1'b1, 8'd64, 16'h1111, 1'b1, 1'b1);
        chk(K_STB, "b2b_stb1", 16'h0001);
        chk(K_OUT, "b2b_out1", 16'h1111);
        tick();
        drv(1'b1, 8'd64, 16'h2222, 1'b1, 1'b1);
        chk(K_STB, "b2b_stb2", 16'h0001);
        chk(K_OUT, "b2b_out2", 16'h2222);
        chk(K_RD, "b2b_rd_old", 16'h1111);
        tick();
        drv(1'b1, 8'd64, 16'h0000, 1'b0, 1'b0);
        chk(K_STB, "b2b_stb_end", 16'h0000);
        chk(K_RD, "b2b_rd", 16'h2222);
        tick();

        // Input change: visible on IN0 after SL extra cycles, flag raised
        io_in = 16'h0042;
        for (int j = 0; j <= SL; j++) begin
            drv(1'b1, 8'd65, 16'h0000, 1'b0, 1'b0);
            chk(K_RD, "in_rd", (j == SL) ? 16'h0042 : 16'h0000);
            tick();
        end
        drv(1'b1, 8'd66, 16'h0000, 1'b0, 1'b0); chk(K_RD, "stat_set", 16'h0001); tick();
        drv(1'b1, 8'd66, 16'h0000, 1'b0, 1'b0); chk(K_RD, "stat_cleared", 16'h0000); tick();

        // Set and clear on the same edge: set wins
        io_in = 16'h0043;
        for (int j = 0; j < SL; j++) begin
            drv(1'b1, 8'd70, 16'h0000, 1'b0, 1'b0); chk(K_RD, "unmapped_wait", 16'h0000); tick();
        end
        drv(1'b1, 8'd66, 16'h0000, 1'b0, 1'b0); chk(K_RD, "stat_coincide", 16'h0000); tick();
        drv(1'b1, 8'd66, 16'h0000, 1'b0, 1'b0); chk(K_RD, "stat_kept", 16'h0001); tick();
        drv(1'b1, 8'd66, 16'h0000, 1'b0, 1'b0); chk(K_RD, "stat_clr2", 16'h0000); tick();

        // Unmapped access
        drv(1'b1, 8'd70, 16'hFFFF, 1'b1, 1'b1);
        chk(K_RD, "unmapped_wr_rd", 16'h0000);
        chk(K_OUT, "unmapped_out", 16'h2222);
        chk(K_STB, "unmapped_stb", 16'h0000);
        tick();
        drv(1'b1, 8'd70, 16'h0000, 1'b0, 1'b0); chk(K_RD, "unmapped_rd", 16'h0000); tick();
        drv(1'b1, 8'd6, 16'h0000, 1'b0, 1'b0); chk(K_RD, "no_wrap_rd6", 16'h0606); tick();

        // Reset overrides a write to OUT0; RAM keeps its content
        drv(1'b0, 8'd64, 16'h5555, 1'b1, 1'b1);
        chk(K_OUT, "rst_wr_out", 16'h0000);
        chk(K_STB, "rst_wr_stb", 16'h0000);
        chk(K_RD, "rst_wr_rd", 16'h0000);
        tick();
        drv(1'b1, 8'd5, 16'h0000, 1'b0, 1'b0); chk(K_RD, "ram_survives_rst", 16'hBEEF); tick();
        drv(1'b1, 8'd66, 16'h0000, 1'b0, 1'b0); chk(K_RD, "stat_post_rst", 16'h0000); tick();

        tick();
        tick();
        if (q.size() != 0) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
